// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file / ALU datapath.
//
//   RD stage (combinational): reads two registers with EX->RD forwarding,
//   selects register or immediate for operand 2. The edge ending the cycle
//   loads the EX register (always; in_valid=0 loads a bubble).
//   EX stage: ALU on the registered operands, eq flag, writeback at the edge
//   ending the EX cycle, retired-operation counter.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    operation present in RD this cycle
//   ad1/ad2     source register addresses
//   ad3/we3     destination register address / write enable
//   alu_src     0: op2 = rd2, 1: op2 = imm_op
//   alu_ctrl    ALU operation (add/sub/and/or/xor/sll/srl/slt)
//   imm_op      sign-extended immediate
//   alu_out     EX-stage ALU result (driven even for bubbles)
//   out_valid   EX stage holds a valid operation
//   eq          EX operands equal, qualified by out_valid
//   a0          registered content of register A0_INDEX
//   retire_cnt  number of valid operations completed (wraps)
module datapath_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int A0_INDEX   = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] ad1,
    input  logic [ADDR_WIDTH-1:0] ad2,
    input  logic [ADDR_WIDTH-1:0] ad3,
    input  logic                  we3,
    input  logic                  alu_src,
    input  logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] imm_op,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  out_valid,
    output logic                  eq,
    output logic [DATA_WIDTH-1:0] a0,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                  SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  ex_valid_q;
    logic [DATA_WIDTH-1:0] ex_op1_q, ex_op2_q;
    alu_op_e               ex_ctrl_q;
    logic [ADDR_WIDTH-1:0] ex_ad3_q;
    logic                  ex_we3_q;
    logic [CNT_WIDTH-1:0]  retire_cnt_q;

    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic [DATA_WIDTH-1:0] ex_op1_d, ex_op2_d;
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] alu_res;

    // A valid EX operation that will write a nonzero register is the only
    // forwarding source; x0 never matches because wb_en excludes it.
    assign wb_en = ex_valid_q && ex_we3_q && (ex_ad3_q != '0);

    // ---------------- RD stage ----------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so the block
        // stays purely combinational and no latch is inferred.
        rd1 = regs_q[ad1];
        rd2 = regs_q[ad2];
        if (wb_en && (ex_ad3_q == ad1)) rd1 = alu_res;
        if (wb_en && (ex_ad3_q == ad2)) rd2 = alu_res;
        if (ad1 == '0) rd1 = '0;
        if (ad2 == '0) rd2 = '0;
        ex_op1_d = rd1;
        ex_op2_d = alu_src ? imm_op : rd2;
    end

    // EX register: always loaded, bubbles included; reset discards any
    // in-flight operation so it never reaches writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs regardless of block order.
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_ctrl_q  <= ALU_ADD;
            ex_ad3_q   <= '0;
            ex_we3_q   <= 1'b0;
        end else begin
            ex_valid_q <= in_valid;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_ctrl_q  <= alu_op_e'(alu_ctrl);
            ex_ad3_q   <= ad3;
            ex_we3_q   <= we3;
        end
    end

    // ---------------- EX stage ----------------
    always_comb begin
        alu_res = '0;
        unique case (ex_ctrl_q)
            ALU_ADD: alu_res = ex_op1_q + ex_op2_q;
            ALU_SUB: alu_res = ex_op1_q - ex_op2_q;
            ALU_AND: alu_res = ex_op1_q & ex_op2_q;
            ALU_OR:  alu_res = ex_op1_q | ex_op2_q;
            ALU_XOR: alu_res = ex_op1_q ^ ex_op2_q;
            ALU_SLL: alu_res = ex_op1_q << ex_op2_q[SHAMT_W-1:0];
            ALU_SRL: alu_res = ex_op1_q >> ex_op2_q[SHAMT_W-1:0];
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}},
                                ($signed(ex_op1_q) < $signed(ex_op2_q))};
            default: alu_res = '0;
        endcase
    end

    // Register file with writeback. x0 is never written, so it holds 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register file is reset on purpose (all entries read 0
            // after reset), which rules out a RAM macro for this array.
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[ex_ad3_q] <= alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else if (ex_valid_q) begin
            retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign alu_out    = alu_res;
    assign out_valid  = ex_valid_q;
    assign eq         = ex_valid_q && (ex_op1_q == ex_op2_q);
    assign a0         = regs_q[A0_ADDR];
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed vector table, hand-written
// reset/counter sequences and randomized operations compared against a
// sequential-execution reference model. A second instance with a 2-bit
// counter shares the stimulus to check counter wrap.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  ad1 = '0, ad2 = '0, ad3 = '0;
    logic        we3 = 1'b0, alu_src = 1'b0;
    logic [2:0]  alu_ctrl = '0;
    logic [31:0] imm_op = '0;

    logic [31:0] alu_out, a0;
    logic        out_valid, eq;
    logic [15:0] retire_cnt;

    logic [31:0] alu_out2, a0_2;
    logic        out_valid2, eq2;
    logic [1:0]  retire_cnt2;

    always #5 clk = ~clk;

    datapath_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_op(imm_op),
        .alu_out(alu_out), .out_valid(out_valid), .eq(eq),
        .a0(a0), .retire_cnt(retire_cnt)
    );

    datapath_pipe #(.CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_op(imm_op),
        .alu_out(alu_out2), .out_valid(out_valid2), .eq(eq2),
        .a0(a0_2), .retire_cnt(retire_cnt2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Forwarding makes the pipeline architecturally sequential, so the model
    // simply executes each operation in order against its register array.
    logic [31:0] mregs [32];
    int          mcnt;
    logic        pend_v;
    logic [31:0] exp_alu, exp_a0;
    logic        exp_v, exp_eq;

    function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcnt   = 0;
        pend_v = 1'b0;
    endtask

    // Drive one operation, advance one edge, leave expectations in exp_*.
    task automatic step(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic w, input logic s,
                        input logic [2:0] c, input logic [31:0] im);
        logic [31:0] op1, op2, res;
        op1 = mregs[a1];
        op2 = s ? im : mregs[a2];
        res = alu_model(c, op1, op2);
        mcnt   = mcnt + (pend_v ? 1 : 0);
        pend_v = v;
        exp_alu = res;
        exp_v   = v;
        exp_eq  = v && (op1 == op2);
        exp_a0  = mregs[10];
        if (v && w && a3 != 5'd0) mregs[a3] = res;
        in_valid = v; ad1 = a1; ad2 = a2; ad3 = a3;
        we3 = w; alu_src = s; alu_ctrl = c; imm_op = im;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges, released between edges.
    task automatic do_reset(input string tag);
        in_valid = 1'b0; we3 = 1'b0;
        #2 rst = 1'b0;
        #1;
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_eq"},        {31'd0, eq},        32'd0);
        check({tag, "_alu_out"},   alu_out,            32'd0);
        check({tag, "_a0"},        a0,                 32'd0);
        check({tag, "_cnt"},       {16'd0, retire_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [4:0]  a1, a2, a3;
        logic        w, s;
        logic [2:0]  c;
        logic [31:0] im;
        logic [31:0] e_alu;
        logic        e_eq;
        logic [31:0] e_a0;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [16];

    initial begin
        //        v   a1 a2 a3  w  s  c  imm             alu            eq a0 cnt
        tbl[0]  = '{1, 0, 0, 10, 1, 1, 0, 32'd5,          32'd5,          0, 0, 0};  // x10 = 5
        tbl[1]  = '{1, 0, 0, 1,  1, 1, 0, 32'd7,          32'd7,          0, 5, 1};  // x1 = 7
        tbl[2]  = '{1, 1, 1, 2,  1, 0, 0, 32'd0,          32'd14,         1, 5, 2};  // x2 = x1+x1
        tbl[3]  = '{1, 2, 0, 0,  0, 1, 0, 32'd0,          32'd14,         0, 5, 3};  // read x2
        tbl[4]  = '{1, 0, 0, 0,  1, 1, 0, 32'hDEAD,       32'hDEAD,       0, 5, 4};  // write x0
        tbl[5]  = '{1, 0, 0, 0,  0, 0, 0, 32'd0,          32'd0,          1, 5, 5};  // read x0
        tbl[6]  = '{1, 0, 0, 3,  1, 1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 5, 6};  // x3 = -1
        tbl[7]  = '{1, 0, 0, 4,  1, 1, 0, 32'd1,          32'd1,          0, 5, 7};  // x4 = 1
        tbl[8]  = '{1, 3, 4, 0,  0, 0, 7, 32'd0,          32'd1,          0, 5, 8};  // slt x3,x4
        tbl[9]  = '{1, 3, 4, 0,  0, 0, 1, 32'd0,          32'hFFFF_FFFE,  0, 5, 9};  // sub x3,x4
        tbl[10] = '{1, 4, 0, 0,  0, 1, 5, 32'd31,         32'h8000_0000,  0, 5, 10}; // sll x4,31
        tbl[11] = '{1, 0, 0, 5,  1, 1, 0, 32'd9,          32'd9,          0, 5, 11}; // x5 = 9
        tbl[12] = '{1, 5, 0, 0,  0, 1, 1, 32'd9,          32'd0,          1, 5, 12}; // 9-9
        tbl[13] = '{0, 5, 0, 0,  0, 1, 1, 32'd9,          32'd0,          0, 5, 13}; // bubble
        tbl[14] = '{1, 0, 0, 0,  0, 1, 2, 32'd3,          32'd0,          0, 5, 13}; // and
        tbl[15] = '{0, 0, 0, 0,  0, 1, 0, 32'd0,          32'd0,          0, 5, 14}; // bubble, eq=0
    end

    initial begin
        model_reset();
        #1;
        do_reset("rst0");

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].w, tbl[i].s, tbl[i].c, tbl[i].im);
            check($sformatf("tbl%0d_alu", i),   alu_out,               tbl[i].e_alu);
            check($sformatf("tbl%0d_valid", i), {31'd0, out_valid},    {31'd0, tbl[i].v});
            check($sformatf("tbl%0d_eq", i),    {31'd0, eq},           {31'd0, tbl[i].e_eq});
            check($sformatf("tbl%0d_a0", i),    a0,                    tbl[i].e_a0);
            check($sformatf("tbl%0d_cnt", i),   {16'd0, retire_cnt},   {16'd0, tbl[i].e_cnt});
        end

        // Write to x5 sits in EX when reset hits mid-stream: it must be lost,
        // and every register must read back 0 afterwards.
        step(1, 0, 0, 5, 1, 1, 0, 32'h55);
        do_reset("rst_mid");
        for (int r = 1; r < 32; r++) begin
            step(1, 5'(r), 0, 0, 0, 1, 0, 32'd0);
            check($sformatf("rd_x%0d_after_rst", r), alu_out, 32'd0);
        end

        // 3 valid operations followed by one bubble.
        do_reset("rst_c3");
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1, 0, 32'(k));
        step(0, 0, 0, 0, 0, 0, 0, 32'd0);
        check("cnt_3v_1b", {16'd0, retire_cnt}, 32'd3);

        // 5 valid operations: 16-bit counter reads 5, 2-bit counter wraps to 1.
        do_reset("rst_c5");
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 1, 0, 32'(k));
        step(0, 0, 0, 0, 0, 0, 0, 32'd0);
        check("cnt16_5v", {16'd0, retire_cnt}, 32'd5);
        check("cnt2_5v_wrap", {30'd0, retire_cnt2}, 32'd1);

        // Randomized operations against the reference model.
        do_reset("rst_rand");
        for (int n = 0; n < 400; n++) begin
            logic        v, w, s;
            logic [4:0]  a1, a2, a3;
            logic [2:0]  c;
            logic [31:0] im;
            v  = ($urandom_range(0, 9) < 8);
            w  = ($urandom_range(0, 3) != 0);
            s  = $urandom_range(0, 1);
            a1 = 5'($urandom_range(0, 11));
            a2 = 5'($urandom_range(0, 11));
            a3 = 5'($urandom_range(0, 11));
            c  = 3'($urandom_range(0, 7));
            im = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            if (n == 200) do_reset("rst_rand_mid");
            step(v, a1, a2, a3, w, s, c, im);
            check("rand_alu",   alu_out,              exp_alu);
            check("rand_valid", {31'd0, out_valid},   {31'd0, exp_v});
            check("rand_eq",    {31'd0, eq},          {31'd0, exp_eq});
            check("rand_a0",    a0,                   exp_a0);
            check("rand_cnt",   {16'd0, retire_cnt},  32'(mcnt % 65536));
            check("rand_cnt2",  {30'd0, retire_cnt2}, 32'(mcnt % 4));
            check("rand2_alu",  alu_out2,             exp_alu);
            check("rand2_flags", {30'd0, out_valid2, eq2}, {30'd0, exp_v, exp_eq});
            check("rand2_a0",   a0_2,                 exp_a0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised two-stage register-file/ALU datapath for the single-issue RISC-V core. Successor to the flat regfile+mux+ALU top.
- Stage 1 (RD) reads the register file with bypass, selects register or immediate for operand 2, and registers operands into the EX register.
- Stage 2 (EX) runs the ALU, drives the eq flag and writes back.
- Adds configurable width and depth, a valid qualifier, EX→RD forwarding, hardwired x0 and a retired-operation counter.

Parameters:
- DATA_WIDTH, 32, register and ALU width.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- A0_INDEX, 10, register index mirrored on a0.
- CNT_WIDTH, 16, retired-operation counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present this cycle.
- ad1  in  ADDR_WIDTH  source register 1.
- ad2  in  ADDR_WIDTH  source register 2.
- ad3  in  ADDR_WIDTH  destination register.
- we3  in  1  write-enable for the destination.
- alu_src  in  1  0: op2 = rd2; 1: op2 = imm_op.
- alu_ctrl  in  3  ALU operation.
- imm_op  in  DATA_WIDTH  sign-extended immediate.
- alu_out  out  DATA_WIDTH  EX-stage ALU result.
- out_valid  out  1  EX stage holds a valid operation.
- eq  out  1  EX operands equal, qualified by out_valid.
- a0  out  DATA_WIDTH  current content of register A0_INDEX.
- retire_cnt  out  CNT_WIDTH  count of valid operations completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers, including x0, go to 0.
  - EX register cleared; out_valid=0, eq=0, alu_out=0, a0=0, retire_cnt=0.
  - An in-flight EX operation is discarded and never written.
  - Release is synchronous to the next clk edge.
- RD stage (cycle N, combinational):
  - rd1 = regs[ad1], rd2 = regs[ad2].
  - Forwarding: if out_valid && ex_we3 && ex_ad3!=0 && ex_ad3==adX, then rdX = alu_out.
  - x0 always reads 0 and is never forwarded.
- EX register capture (edge ending cycle N):
  - Captures op1 = rd1 and op2 = alu_src ? imm_op : rd2.
  - Also captures alu_ctrl, ad3, we3, and ex_valid = in_valid.
  - The EX register is always loaded; in_valid=0 inserts a bubble.
- EX stage (cycle N+1, combinational). ALU ops, all modulo 2**DATA_WIDTH, unsigned unless stated:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 sll by op2[log2(DATA_WIDTH)-1:0].
  - 110 srl by the same shift amount.
  - 111 slt, signed: result 1 if op1<op2, else 0.
- EX outputs:
  - alu_out is driven even when out_valid=0.
  - eq = out_valid && (op1==op2), compared on the operands, independent of alu_ctrl.
- Writeback (edge ending cycle N+1):
  - If ex_valid && ex_we3 && ex_ad3!=0: regs[ex_ad3] <= alu_out.
  - Writes to x0 are silently dropped.
- retire_cnt increments by 1 at each edge where ex_valid=1, independent of we3. Wraps from 2**CNT_WIDTH-1 to 0.
- Latency: result written 2 edges after the operation is presented. Back-to-back dependent operations need no stall.
- a0 reflects register A0_INDEX after writeback (registered value); it updates the cycle after the write edge.
- Simultaneous cases:
  - A writeback and a new read of the same register in one cycle resolve via forwarding; the new value is seen.
  - ad1==ad2 gets both ports forwarded.

Test Plan:
- Reset, then check outputs: rst=0 mid-stream → out_valid=0, eq=0, a0=0, retire_cnt=0, and reads of x1..x31 return 0.
- Immediate write, then read back:
  - Op 1: alu_src=1, imm_op=5, ad1=0, alu_ctrl=000, ad3=10, we3=1 → alu_out=5 in the next cycle, a0=5 one cycle after writeback.
- Forwarding chain:
  - x1=7 (imm), then x2=x1+x1 (ad1=ad2=1, alu_src=0) issued back-to-back → alu_out=14; x2 reads 14.
- x0 protection: write imm 0xDEAD to ad3=0 → x0 still reads 0; no forwarding of 0xDEAD to a following read of x0.
- ALU and eq coverage:
  - x3=0xFFFFFFFF, x4=1; slt x3,x4 → 1; sltu-style sub → 0xFFFFFFFE; sll 1 by 31 → 0x80000000.
  - Operands 9,9 with alu_ctrl=001 → alu_out=0, eq=1.
  - Bubble (in_valid=0) → eq=0.
- Counter and reset-in-flight:
  - 3 valid ops plus 1 bubble → retire_cnt=3.
  - Assert rst while a write to x5 is in EX → x5 stays 0.
  - With CNT_WIDTH=2, 5 valid ops → retire_cnt=1.
